// File: rtl/muldiv_seq.sv
// muldiv_seq: sequencer for the shared multi-cycle RV32M unit in Execute.
// One MUL*/DIV*/REM* request is handled at a time. The unit runs either a
// DATA_WIDTH-step shift-add multiply or a restoring divide on one shared
// accumulator, then presents the sign-corrected result with isDone.
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   startE   M-extension instruction present in Execute
//   funct3E  000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//   srcAE    rs1 value (forwarded)
//   srcBE    rs2 value (forwarded)
//   flushE   Execute flush: abort the current operation
//   holdM    downstream stall: keep the result presented while high
//   stallE   freeze PC, F/D and D/E while the request is accepted or running
//   isDone   result valid this cycle
//   resultE  result, zero outside DONE
module muldiv_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  startE,
    input  logic [2:0]            funct3E,
    input  logic [DATA_WIDTH-1:0] srcAE,
    input  logic [DATA_WIDTH-1:0] srcBE,
    input  logic                  flushE,
    input  logic                  holdM,
    output logic                  stallE,
    output logic                  isDone,
    output logic [DATA_WIDTH-1:0] resultE
);

    localparam int W  = DATA_WIDTH;
    localparam int AW = 2 * DATA_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [CNT_WIDTH-1:0] cnt;
    // Multiply: {carry, product high, multiplier/product low}.
    // Divide:   {unused 0, remainder, quotient being shifted in}.
    logic [AW-1:0]        acc;
    logic [W-1:0]         opb;      // multiplicand magnitude or divisor magnitude
    logic [2:0]           op;
    logic                 sign_a;
    logic                 sign_b;

    // ---------------- request decode ----------------
    logic         start_ok;
    logic         is_div_in;
    logic         a_signed_in, b_signed_in;
    logic         neg_a_in, neg_b_in;
    logic [W-1:0] mag_a_in, mag_b_in;
    logic         div_by_zero, div_ovf, special_in;

    always_comb begin
        start_ok    = (state == S_IDLE) && startE && !flushE;
        is_div_in   = funct3E[2];
        // Signed ops: MUL, MULH, MULHSU (A only), DIV, REM.
        a_signed_in = is_div_in ? !funct3E[0] : (funct3E != 3'b011);
        b_signed_in = is_div_in ? !funct3E[0] : !funct3E[1];
        neg_a_in    = a_signed_in && srcAE[W-1];
        neg_b_in    = b_signed_in && srcBE[W-1];
        mag_a_in    = neg_a_in ? (~srcAE + 1'b1) : srcAE;
        mag_b_in    = neg_b_in ? (~srcBE + 1'b1) : srcBE;
        div_by_zero = (srcBE == '0);
        div_ovf     = !funct3E[0] && (srcAE == {1'b1, {(W-1){1'b0}}}) && (srcBE == '1);
        special_in  = is_div_in && (div_by_zero || div_ovf);
    end

    // ---------------- one iteration ----------------
    logic [W:0]    mul_upper;
    logic [AW-1:0] mul_next;
    logic [W:0]    rem_sh;
    logic [W:0]    div_diff;
    logic          div_ge;
    logic [AW-1:0] div_next;

    always_comb begin
        // Add into the 33-bit upper half so the carry survives the shift.
        mul_upper = acc[AW-1:W] + {1'b0, (acc[0] ? opb : {W{1'b0}})};
        mul_next  = {1'b0, mul_upper, acc[W-1:1]};

        // Remainder stays below the divisor, so the borrow bit alone tells
        // whether the shifted remainder reaches the divisor.
        rem_sh    = {acc[2*W-1:W], acc[W-1]};
        div_diff  = rem_sh - {1'b0, opb};
        div_ge    = !div_diff[W];
        div_next  = {1'b0, (div_ge ? div_diff[W-1:0] : rem_sh[W-1:0]), acc[W-2:0], div_ge};
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (start_ok) state_n = special_in ? S_DONE : S_BUSY;
            S_BUSY: begin
                if (flushE)                              state_n = S_IDLE;
                else if (cnt == CNT_WIDTH'(W - 1))       state_n = S_DONE;
            end
            S_DONE: if (flushE || !holdM)                state_n = S_IDLE;
            default:                                     state_n = S_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            op     <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        op  <= funct3E;
                        cnt <= '0;
                        if (special_in) begin
                            // Final values loaded directly; no sign fixup applies.
                            sign_a <= 1'b0;
                            sign_b <= 1'b0;
                            opb    <= '0;
                            if (div_by_zero) acc <= {1'b0, srcAE, {W{1'b1}}};
                            else             acc <= {1'b0, {W{1'b0}}, 1'b1, {(W-1){1'b0}}};
                        end else begin
                            sign_a <= neg_a_in;
                            sign_b <= neg_b_in;
                            opb    <= mag_b_in;
                            acc    <= {{(W+1){1'b0}}, mag_a_in};
                        end
                    end
                end
                S_BUSY: begin
                    if (!flushE) begin
                        cnt <= cnt + 1'b1;
                        acc <= op[2] ? div_next : mul_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- outputs ----------------
    logic [2*W-1:0] prod, prod_f;
    logic [W-1:0]   quo_f, rem_f;

    always_comb begin
        prod    = acc[2*W-1:0];
        prod_f  = (sign_a ^ sign_b) ? (~prod + 1'b1) : prod;
        quo_f   = (sign_a ^ sign_b) ? (~acc[W-1:0] + 1'b1) : acc[W-1:0];
        rem_f   = sign_a ? (~acc[2*W-1:W] + 1'b1) : acc[2*W-1:W];

        stallE  = ((state == S_IDLE) && startE && !flushE) ||
                  ((state == S_BUSY) && !flushE);
        isDone  = (state == S_DONE);
        resultE = '0;
        if (state == S_DONE) begin
            case (op)
                3'b000:                 resultE = prod_f[W-1:0];
                3'b001, 3'b010, 3'b011: resultE = prod_f[2*W-1:W];
                3'b100, 3'b101:         resultE = quo_f;
                default:                resultE = rem_f;
            endcase
        end
    end

endmodule
